vga_tx: RTL
===========

# vga_tx

Transmit side of the frame buffer. Scans a fixed VGA raster, reads the 8-bit greyscale pixels the capture side wrote into the block RAM, and drives the monitor's sync, data-enable and pixel outputs. It sits between the frame-buffer BRAM read port and the VGA DAC pins, and runs entirely in the VGA pixel clock domain.

## Interface
Parameters:
- H_VISIBLE, 640: visible pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync widths, in pixels
- V_VISIBLE, 480: visible lines
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync widths, in lines
- SRC_W, 128 / SRC_H, 96: stored image size. SRC_W*SRC_H must not exceed 2^14.
- X0, 256 / Y0, 192: top-left raster position of the stored image
- BORDER_COLOR, 8'h10: fill for visible pixels outside the image (only used with the macro)

Ports:
- V_CLK  in  1  pixel clock
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  raster runs while high
- BRAM_ADDR  out  14  frame-buffer read address
- BRAM_RE  out  1  read strobe
- BRAM_DOUT  in  8  read data, valid one cycle after the address
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_DE  out  1  visible-area flag
- VGA_DATA  out  8  pixel intensity
- FRAME_START  out  1  one-cycle pulse at raster (0,0)

## Operation
- Counters:
  - H_COUNT runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - V_COUNT advances when H_COUNT wraps and runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - Both counters are stage-0 registers.
- Sync:
  - HS is low for H_VISIBLE+H_FRONT ≤ H_COUNT < H_VISIBLE+H_FRONT+H_SYNC.
  - VS is low for the corresponding V_COUNT range.
  - DE is high when H_COUNT < H_VISIBLE and V_COUNT < V_VISIBLE.
- Image region: X0 ≤ H_COUNT < X0+SRC_W and Y0 ≤ V_COUNT < Y0+SRC_H.
- Addressing (incremental, no multiplier):
  - ROW_BASE is cleared at frame start.
  - On the first pixel of each in-region line, the address is loaded from ROW_BASE, then increments by 1 per in-region pixel.
  - At the end of each in-region line, ROW_BASE += SRC_W.
  - The sequence is 0..SRC_W*SRC_H-1 per frame and never exceeds it.
- BRAM_RE is high exactly for in-region pixels. BRAM_ADDR holds its last value otherwise.
- Output pixel selection:
  - In-region pixel: BRAM_DOUT.
  - Visible but outside the region: fill value (see Configuration).
  - Not visible: 0.
- ENABLE low:
  - Counters and ROW_BASE clear to 0 on the next edge.
  - Outputs take their reset values.
  - When ENABLE rises, the raster restarts at (0,0).
- RESET has priority over ENABLE. Every output and counter resets on the next edge, including mid-line and mid-frame.

## Timing
- Reset values: BRAM_ADDR=0, BRAM_RE=0, VGA_HS=1, VGA_VS=1, VGA_DE=0, VGA_DATA=0, FRAME_START=0.
- Pipeline:
  - Stage 0: counters.
  - Stage 1: registered BRAM_ADDR/BRAM_RE and delayed flags.
  - Stage 2: registered VGA outputs.
- Latency: the pixel for counter value (x,y) appears on all VGA outputs 2 cycles after H_COUNT=x, V_COUNT=y. HS, VS, DE and FRAME_START are delayed identically, so raster geometry is unchanged.
- The BRAM read issued in stage 1 is consumed in stage 2. The BRAM port must have exactly 1-cycle read latency.
- FRAME_START period is H_TOTAL*V_TOTAL = 420000 cycles.
- Wrap boundary: at H_COUNT=799 and V_COUNT=524, both counters wrap to 0 on the same edge.

## Configuration
- VGA_TX_BORDER_EN defined: visible pixels outside the image region output BORDER_COLOR.
- VGA_TX_BORDER_EN undefined: those pixels output 0, and BORDER_COLOR is unused.
- The macro has no effect on sync, DE, address or latency behaviour.

## Test plan
- Reset and idle:
  - Hold RESET 5 cycles. All outputs must equal their reset values.
  - Release with ENABLE=1. FRAME_START must pulse 2 cycles later.
  - FRAME_START must then recur every 420000 cycles.
- Line timing:
  - HS must go low 658 cycles after FRAME_START's line start and stay low for 96 cycles.
  - DE must be high for 640 cycles per visible line and low on lines 480..524.
  - VS must be low for exactly lines 490..491.
- Address sequence:
  - BRAM_RE must first rise at (256,192) with BRAM_ADDR=0.
  - The first row must end at address 127, and the next row must start at 128.
  - The last read of the frame must be at 12287, with 12288 reads total per frame.
- Data path:
  - Preload the BRAM model with pattern addr[7:0].
  - VGA_DATA at raster (260,193) must equal 132.
- Border macro:
  - With VGA_TX_BORDER_EN, pixel (0,0) must output 8'h10.
  - Without the macro, pixel (0,0) must output 0.
  - Pixels in the blanking interval must be 0 in both builds.
- Mid-frame interrupts:
  - Drop ENABLE at line 300 for 10 cycles. Outputs must go idle, and after ENABLE rises the raster must restart at (0,0) with BRAM_ADDR restarting at 0.
  - Repeat with a RESET pulse; the required behaviour is the same.

Source files
------------

// File: rtl/vga_tx.sv
// vga_tx: VGA raster generator reading 8-bit greyscale pixels from the
// frame-buffer BRAM and driving sync, data-enable and pixel outputs.
// Three-stage pipeline: counters, BRAM address/flags, VGA outputs.
// Optional macro VGA_TX_BORDER_EN: fill visible pixels outside the stored
// image with BORDER_COLOR instead of black.
`timescale 1ns/1ps

module vga_tx #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter int unsigned SRC_W        = 128,
  parameter int unsigned SRC_H        = 96,
  parameter int unsigned X0           = 256,
  parameter int unsigned Y0           = 192,
  parameter logic [7:0]  BORDER_COLOR = 8'h10
) (
  input  logic        V_CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic [13:0] BRAM_ADDR,
  output logic        BRAM_RE,
  input  logic [7:0]  BRAM_DOUT,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_DE,
  output logic [7:0]  VGA_DATA,
  output logic        FRAME_START
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] X_BEG     = HW'(X0);
  localparam logic [HW-1:0] X_END     = HW'(X0 + SRC_W);
  localparam logic [HW-1:0] X_LAST    = HW'(X0 + SRC_W - 1);

  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] Y_BEG     = VW'(Y0);
  localparam logic [VW-1:0] Y_END     = VW'(Y0 + SRC_H);

  localparam logic [13:0] ROW_STEP = 14'(SRC_W);

  // Stage 0: raster counters and the base address of the current image row
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [13:0]   row_base_q, row_base_d;

  // Stage 1: BRAM read request and raster flags delayed by one cycle
  logic [13:0] addr_q, addr_d;
  logic        re_q, re_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic        de1_q, de1_d;
  logic        fs1_q, fs1_d;

  // Stage 2: VGA-side registers, aligned with the BRAM read data
  logic        hs2_q, hs2_d;
  logic        vs2_q, vs2_d;
  logic        de2_q, de2_d;
  logic        fs2_q, fs2_d;
  logic        inreg2_q, inreg2_d;
  logic [7:0]  fill2_q, fill2_d;

  logic h_wrap;
  logic frame_wrap;
  logic in_region;

`ifndef VGA_TX_BORDER_EN
  logic unused_border;
  assign unused_border = ^BORDER_COLOR;
`endif

  // Next-state logic for every pipeline stage, computed from the current flops
  always_comb begin
    h_wrap     = (h_cnt_q == H_LAST);
    frame_wrap = h_wrap && (v_cnt_q == V_LAST);
    in_region  = (h_cnt_q >= X_BEG) && (h_cnt_q < X_END) &&
                 (v_cnt_q >= Y_BEG) && (v_cnt_q < Y_END);

    h_cnt_d    = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d    = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end

    row_base_d = row_base_q;
    if (frame_wrap) begin
      row_base_d = '0;
    end else if (in_region && (h_cnt_q == X_LAST)) begin
      row_base_d = row_base_q + ROW_STEP;
    end

    addr_d = addr_q;
    if (in_region) begin
      addr_d = (h_cnt_q == X_BEG) ? row_base_q : addr_q + 14'd1;
    end
    re_d  = in_region;
    hs1_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs1_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    de1_d = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    fs1_d = (h_cnt_q == '0) && (v_cnt_q == '0);

    hs2_d    = hs1_q;
    vs2_d    = vs1_q;
    de2_d    = de1_q;
    fs2_d    = fs1_q;
    inreg2_d = re_q;
`ifdef VGA_TX_BORDER_EN
    fill2_d  = (de1_q && !re_q) ? BORDER_COLOR : 8'h00;
`else
    fill2_d  = 8'h00;
`endif
  end

  // Pipeline registers; reset and a low ENABLE both return everything to idle
  always_ff @(posedge V_CLK) begin
    if (RESET || !ENABLE) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      re_q       <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      de1_q      <= 1'b0;
      fs1_q      <= 1'b0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
      de2_q      <= 1'b0;
      fs2_q      <= 1'b0;
      inreg2_q   <= 1'b0;
      fill2_q    <= 8'h00;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      de1_q      <= de1_d;
      fs1_q      <= fs1_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      de2_q      <= de2_d;
      fs2_q      <= fs2_d;
      inreg2_q   <= inreg2_d;
      fill2_q    <= fill2_d;
    end
  end

  assign BRAM_ADDR   = addr_q;
  assign BRAM_RE     = re_q;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_DE      = de2_q;
  assign FRAME_START = fs2_q;
  // The BRAM output register supplies the stage-2 data; only the select is ours
  assign VGA_DATA    = inreg2_q ? BRAM_DOUT : fill2_q;

endmodule
